sel_mux_arb: RTL and testbench

SEL_MUX_ARB -- requirements
Module: sel_mux_arb

---
 rtl/sel_mux_arb_pkg.sv | 14 +
 rtl/sel_mux_arb_rr_arbiter.sv | 29 ++
 rtl/sel_mux_arb.sv | 112 +++++++++++
 tb/tb_sel_mux_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_mux_arb_pkg.sv
// Shared definitions for the selectable mux / round-robin arbiter block.
package sel_mux_arb_pkg;

    // Operating mode as presented on the mode input.
    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N     = 5;
    localparam int DEFAULT_SEL_W = 3;

endpackage

// File: rtl/sel_mux_arb_rr_arbiter.sv
// Round-robin grant: first requester after ptr, wrapping modulo N.
module rr_arbiter
    import sel_mux_arb_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any_grant
);

    // Scan ptr+1, ptr+2, ... ptr+N (mod N); the last step revisits ptr itself.
    always_comb begin : search
        int idx;
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sel_mux_arb.sv
// N-channel mux with direct-select or round-robin arbitration into a
// single registered output stage.
//
// Handshake: a word moves from channel g to the output register on a rising
// edge where in_valid[g] is granted and in_ready[g] is high; in_ready is only
// ever high for the granted channel and only when the output register can
// take a word (empty, or being drained by out_ready this cycle). Downstream
// takes out_data on an edge where out_valid and out_ready are both high.
module sel_mux_arb
    import sel_mux_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    logic             accept;
    logic             sel_ok;
    logic             has_grant;
    logic             xfer;
    logic             rr_any;
    logic [N-1:0]     rr_grant;
    logic [N-1:0]     dir_grant;
    logic [N-1:0]     grant_oh;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] ptr;

    // Extra bit keeps the compare correct when N == 2**SEL_W.
    assign sel_ok = {1'b0, sel} < (SEL_W + 1)'(N);

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (rr_grant),
        .any_grant (rr_any)
    );

    // Direct-mode grant: the selected channel, only if it exists and is valid.
    always_comb begin
        dir_grant = '0;
        if (sel_ok) begin
            dir_grant[sel] = in_valid[sel];
        end
    end

    // Mode switch is purely combinational so it takes effect the same cycle.
    always_comb begin
        grant_oh  = (mode == MODE_RR) ? rr_grant : dir_grant;
        has_grant = (mode == MODE_RR) ? rr_any : (|dir_grant);
    end

    // One-hot grant to channel index for the data mux and ptr update.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_oh[i]) begin
                grant_idx = SEL_W'(i);
            end
        end
    end

    assign accept   = !out_valid || out_ready;
    assign xfer     = has_grant && accept;
    assign in_ready = grant_oh & {N{accept && reset}};

    // Output register: load on transfer, drain on out_ready, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer remembers the last channel served in either mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= SEL_W'(N - 1);
        end else if (xfer) begin
            ptr <= grant_idx;
        end
    end

    // Sticky flag for an out-of-range select seen in direct mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_err <= 1'b0;
        end else if (mode == MODE_DIRECT && !sel_ok) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sel_mux_arb.sv
// Self-checking bench for sel_mux_arb (N=5, WIDTH=32).
module tb_sel_mux_arb;

    localparam int WIDTH = 32;
    localparam int N     = 5;
    localparam int SEL_W = 3;

    logic               clk;
    logic               reset;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic               sel_err;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];

    sel_mux_arb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] pat_word(input int i);
        return 32'hCAFE0000 | WIDTH'(i);
    endfunction

    task automatic load_pattern();
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = pat_word(i);
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        load_pattern();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Reference: grant index from the rules, -1 for none.
    function automatic int ref_grant(input logic m, input int s, input logic [N-1:0] v, input int p);
        if (!m) begin
            if (s < N && v[s]) return s;
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [N-1:0]     valid;
        logic [N-1:0]     exp_ready;
        logic             exp_ov;
        logic [WIDTH-1:0] exp_od;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] exp_w;
        int               exp_ch;
        int               m_ptr;
        logic             m_ov;
        logic [WIDTH-1:0] m_od;
        logic             m_err;
        logic [WIDTH-1:0] words[N];
        int               g;
        logic [N-1:0]     e_rdy;

        tbl[0] = '{3'd2, 5'b00100, 5'b00100, 1'b1, 32'hCAFE0002};
        tbl[1] = '{3'd0, 5'b00001, 5'b00001, 1'b1, 32'hCAFE0000};
        tbl[2] = '{3'd4, 5'b11111, 5'b10000, 1'b1, 32'hCAFE0004};
        tbl[3] = '{3'd3, 5'b10111, 5'b00000, 1'b0, 32'hCAFE0004};
        tbl[4] = '{3'd1, 5'b00010, 5'b00010, 1'b1, 32'hCAFE0001};

        // Reset values while reset is held low
        reset = 1'b0; mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
        load_pattern();
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sel_err", 32'(sel_err), 0);
        chk("rst_in_ready", 32'(in_ready), 0);

        // Direct-mode table
        apply_reset();
        for (int t = 0; t < 5; t++) begin
            mode = 1'b0; sel = tbl[t].sel; in_valid = tbl[t].valid; out_ready = 1'b1;
            #1;
            chk($sformatf("tbl%0d_in_ready", t), 32'(in_ready), 32'(tbl[t].exp_ready));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_out_valid", t), 32'(out_valid), 32'(tbl[t].exp_ov));
            chk($sformatf("tbl%0d_out_data", t), out_data, tbl[t].exp_od);
            chk($sformatf("tbl%0d_sel_err", t), 32'(sel_err), 0);
            @(negedge clk);
        end

        // Out-of-range select is rejected and sticks
        apply_reset();
        mode = 1'b0; sel = 3'd6; in_valid = '1; out_ready = 1'b1;
        #1;
        chk("selerr_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("selerr_out_valid", 32'(out_valid), 0);
        chk("selerr_flag", 32'(sel_err), 1);
        @(negedge clk);
        sel = 3'd0;
        @(posedge clk); #1;
        chk("selerr_sticky", 32'(sel_err), 1);
        chk("selerr_then_sel0", out_data, pat_word(0));
        @(negedge clk);

        // Round-robin sweep after reset, wrapping past channel 4
        apply_reset();
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(pat_word(i % N));
        for (int i = 0; i < 6; i++) begin
            exp_ch = i % N;
            #1;
            chk($sformatf("rr_sweep%0d_in_ready", i), 32'(in_ready), 32'(1 << exp_ch));
            @(posedge clk); #1;
            exp_w = exp_q.pop_front();
            chk($sformatf("rr_sweep%0d_out_data", i), out_data, exp_w);
            @(negedge clk);
        end

        // Back-pressure for three cycles, then release
        out_ready = 1'b0;
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_out_data", i), out_data, held);
            chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'(5'b00010));
        @(posedge clk); #1;
        chk("bp_release_out_data", out_data, pat_word(1));
        @(negedge clk);

        // Pointer at 3 with channels 0 and 1 requesting
        apply_reset();
        mode = 1'b1; in_valid = 5'b01000; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ptr3_setup", out_data, pat_word(3));
        @(negedge clk);
        in_valid = 5'b00011;
        #1;
        chk("ptr3_first_ready", 32'(in_ready), 32'(5'b00001));
        @(posedge clk); #1;
        chk("ptr3_first_data", out_data, pat_word(0));
        @(negedge clk);
        #1;
        chk("ptr3_second_ready", 32'(in_ready), 32'(5'b00010));
        @(posedge clk); #1;
        chk("ptr3_second_data", out_data, pat_word(1));

        // Asynchronous reset while holding a word
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        chk("async_pre_valid", 32'(out_valid), 1);
        reset = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_out_data", out_data, 0);
        chk("async_in_ready", 32'(in_ready), 0);

        // Randomized traffic against the reference model
        apply_reset();
        m_ptr = N - 1; m_ov = 1'b0; m_od = '0; m_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = SEL_W'($urandom_range(0, 7));
            in_valid  = N'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                words[i] = $urandom;
                in_data[i*WIDTH +: WIDTH] = words[i];
            end
            g = ref_grant(mode, int'(sel), in_valid, m_ptr);
            e_rdy = '0;
            if (g >= 0 && (!m_ov || out_ready)) e_rdy[g] = 1'b1;
            #1;
            chk($sformatf("rnd%0d_in_ready", c), 32'(in_ready), 32'(e_rdy));
            @(posedge clk);
            if (g >= 0 && (!m_ov || out_ready)) begin
                m_od  = words[g];
                m_ov  = 1'b1;
                m_ptr = g;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (!mode && int'(sel) >= N) m_err = 1'b1;
            #1;
            chk($sformatf("rnd%0d_out_valid", c), 32'(out_valid), 32'(m_ov));
            chk($sformatf("rnd%0d_out_data", c), out_data, m_od);
            chk($sformatf("rnd%0d_sel_err", c), 32'(sel_err), 32'(m_err));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
